// File: rtl/secuenciador_suma_pkg.sv
// Shared state encoding and Q-format defaults for the accumulate sequencer.
package secuenciador_suma_pkg;

  localparam int unsigned LARGO_DEF = 11;
  localparam int unsigned MAG_DEF   = 4;
  localparam int unsigned PRES_DEF  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACUM   = 2'd1,
    SALIDA = 2'd2
  } estado_t;

endpackage

// File: rtl/secuenciador_suma_sumador_sat.sv
// Combinational signed adder with saturation to the largo+1 bit range.
module sumador_sat
  import secuenciador_suma_pkg::*;
#(
  parameter int unsigned largo = LARGO_DEF
) (
  input  logic signed [largo:0] a,
  input  logic signed [largo:0] b,
  output logic signed [largo:0] y,
  output logic                  sat
);

  logic signed [largo+1:0] ext;

  always_comb begin
    ext = {a[largo], a} + {b[largo], b};
    sat = 1'b0;
    y   = ext[largo:0];
    // Top two bits disagree only when the sum left the representable range.
    if (ext[largo+1] != ext[largo]) begin
      sat = 1'b1;
      y   = ext[largo+1] ? {1'b1, {largo{1'b0}}} : {1'b0, {largo{1'b1}}};
    end
  end

endmodule

// File: rtl/secuenciador_suma.sv
// Accumulates taps signed terms with saturation, then presents the sum
// through a valid/ready handshake.
module secuenciador_suma
  import secuenciador_suma_pkg::*;
#(
  parameter int unsigned largo = LARGO_DEF,
  parameter int unsigned mag   = MAG_DEF,
  parameter int unsigned pres  = PRES_DEF,
  parameter int unsigned taps  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inicio,
  input  logic signed [largo:0] dato,
  input  logic                  dato_valido,
  output logic                  dato_listo,
  output logic signed [largo:0] y,
  output logic                  y_valido,
  input  logic                  y_listo,
  output logic                  overflow,
  output logic                  ocupado
);

  localparam int unsigned CW = (taps > 1) ? $clog2(taps) : 1;

  // The Q format must exactly fill the data word (sign + mag + pres).
  if (mag + pres != largo) begin : g_fmt_chk
    $error("secuenciador_suma: mag + pres must equal largo");
  end

  estado_t                estado;
  logic signed [largo:0]  acc;
  logic        [CW-1:0]   cnt;
  logic signed [largo:0]  suma;
  logic                   sat;

  sumador_sat #(.largo(largo)) u_sumador (
    .a   (acc),
    .b   (dato),
    .y   (suma),
    .sat (sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      y          <= '0;
      overflow   <= 1'b0;
      y_valido   <= 1'b0;
      dato_listo <= 1'b0;
      ocupado    <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (inicio) begin
            acc        <= '0;
            cnt        <= '0;
            overflow   <= 1'b0;
            estado     <= ACUM;
            dato_listo <= 1'b1;
            ocupado    <= 1'b1;
          end
        end
        ACUM: begin
          if (dato_listo && dato_valido) begin
            acc      <= suma;
            overflow <= overflow | sat;
            // Last term: publish the result on the same edge.
            if (cnt == CW'(taps - 1)) begin
              estado     <= SALIDA;
              y          <= suma;
              y_valido   <= 1'b1;
              dato_listo <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        SALIDA: begin
          if (y_listo) begin
            estado   <= IDLE;
            y_valido <= 1'b0;
            ocupado  <= 1'b0;
          end
        end
        default: begin
          estado     <= IDLE;
          y_valido   <= 1'b0;
          dato_listo <= 1'b0;
          ocupado    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_suma.sv
// Directed-vector bench for secuenciador_suma with default parameters.
module tb_secuenciador_suma;

  logic               clk = 1'b0;
  logic               reset;
  logic               inicio;
  logic signed [11:0] dato;
  logic               dato_valido;
  logic               dato_listo;
  logic signed [11:0] y;
  logic               y_valido;
  logic               y_listo;
  logic               overflow;
  logic               ocupado;

  int total = 0;
  int bad   = 0;

  secuenciador_suma dut (
    .clk         (clk),
    .reset       (reset),
    .inicio      (inicio),
    .dato        (dato),
    .dato_valido (dato_valido),
    .dato_listo  (dato_listo),
    .y           (y),
    .y_valido    (y_valido),
    .y_listo     (y_listo),
    .overflow    (overflow),
    .ocupado     (ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%03h expected=0x%03h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  task automatic send(input logic [11:0] d);
    dato        = d;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
  endtask

  task automatic handshake();
    y_listo = 1'b1;
    tick();
    y_listo = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; inicio = 1'b0; dato = '0; dato_valido = 1'b0; y_listo = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_y", y, 12'h000);
    chk("rst_yv", y_valido, 0);
    chk("rst_listo", dato_listo, 0);
    chk("rst_ocup", ocupado, 0);
    chk("rst_ovf", overflow, 0);

    // Five terms of 1.0 with dato_valido held high
    start_run();
    chk("t1_listo", dato_listo, 1);
    chk("t1_ocup", ocupado, 1);
    for (int i = 0; i < 4; i++) send(12'h080);
    chk("t1_yv_pre", y_valido, 0);
    send(12'h080);
    chk("t1_yv", y_valido, 1);
    chk("t1_y", y, 12'h280);
    chk("t1_ovf", overflow, 0);
    chk("t1_listo_off", dato_listo, 0);
    handshake();
    chk("t1_idle_yv", y_valido, 0);
    chk("t1_idle_ocup", ocupado, 0);
    chk("t1_hold_y", y, 12'h280);

    // Positive saturation, first hit on the third term
    start_run();
    chk("t2_ovf_clr", overflow, 0);
    send(12'h380); send(12'h380);
    chk("t2_ovf_2", overflow, 0);
    send(12'h380);
    chk("t2_ovf_3", overflow, 1);
    send(12'h380); send(12'h380);
    chk("t2_y", y, 12'h7FF);
    chk("t2_ovf", overflow, 1);
    chk("t2_yv", y_valido, 1);
    handshake();

    // Exact minimum does not overflow; further negatives saturate
    start_run();
    send(12'hC00); send(12'hC00);
    chk("t3_acc", dut.acc, 12'h800);
    chk("t3_ovf_2", overflow, 0);
    send(12'hC00); send(12'hC00); send(12'hC00);
    chk("t3_y", y, 12'h800);
    chk("t3_ovf", overflow, 1);
    handshake();

    // Sparse dato_valido, garbage on idle cycles, delayed y_listo
    start_run();
    for (int k = 0; k < 5; k++) begin
      send(12'(16 * (k + 1)));
      if (k < 4) begin
        chk("t4_listo", dato_listo, 1);
        for (int g = 0; g < 2; g++) begin
          dato = 12'h7FF;
          tick();
        end
      end
    end
    chk("t4_yv", y_valido, 1);
    chk("t4_y", y, 12'h0F0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t4_hold_y", y, 12'h0F0);
      chk("t4_hold_yv", y_valido, 1);
      chk("t4_hold_ovf", overflow, 0);
    end
    inicio = 1'b1;
    handshake();
    inicio = 1'b0;
    chk("t4_hs_ocup", ocupado, 0);
    chk("t4_hs_listo", dato_listo, 0);

    // inicio mid-run ignored
    start_run();
    send(12'h040); send(12'h040);
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    chk("t5_listo", dato_listo, 1);
    send(12'h040); send(12'h040);
    chk("t5_yv_pre", y_valido, 0);
    send(12'h040);
    chk("t5_yv", y_valido, 1);
    chk("t5_y", y, 12'h140);
    handshake();

    // Reset mid-run, then a fresh run
    start_run();
    send(12'h380); send(12'h380); send(12'h380);
    chk("t6_ovf_pre", overflow, 1);
    reset = 1'b1;
    inicio = 1'b1;
    tick();
    reset = 1'b0;
    inicio = 1'b0;
    chk("t6_y", y, 12'h000);
    chk("t6_ovf", overflow, 0);
    chk("t6_yv", y_valido, 0);
    chk("t6_listo", dato_listo, 0);
    chk("t6_ocup", ocupado, 0);
    start_run();
    for (int i = 0; i < 5; i++) send(12'h100);
    chk("t6_new_y", y, 12'h500);
    chk("t6_new_ovf", overflow, 0);
    chk("t6_new_yv", y_valido, 1);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
